bert_drp_arbiter: RTL and testbench

Shares one GTX transceiver DRP port (drp_clk domain) between two independent requesters: port A, the management path after clock-domain shifting, and port B, an internal lane sequencer such as an eye-scan or rate-change engine. Each port issues single-cycle command strobes. The block buffers one command per port, arbitrates round-robin, and runs exactly one DRP transaction at a time. It returns read data and a done strobe to the owning port, with an optional watchdog for a DRP that never answers.

---
 rtl/bert_drp_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_bert_drp_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bert_drp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bert_drp_arbiter
// Purpose  : Shares one GTX DRP port between two requesters (A: management,
//            B: lane sequencer). One-deep command buffer per port,
//            round-robin arbitration, one DRP transaction at a time.
// Options  : BERT_DRP_TIMEOUT_EN - adds a watchdog that aborts a transaction
//            when drp_rdy never arrives (TIMEOUT_CYCLES wait cycles).
// Revision : 1.0 - initial release
// ============================================================================
module bert_drp_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        drp_clk_i,
  input  logic        rst_i,
  // Port A
  input  logic        a_en_i,
  input  logic        a_we_i,
  input  logic [8:0]  a_addr_i,
  input  logic [15:0] a_wdata_i,
  output logic [15:0] a_rdata_o,
  output logic        a_done_o,
  output logic        a_err_o,
  output logic        a_timeout_o,
  // Port B
  input  logic        b_en_i,
  input  logic        b_we_i,
  input  logic [8:0]  b_addr_i,
  input  logic [15:0] b_wdata_i,
  output logic [15:0] b_rdata_o,
  output logic        b_done_o,
  output logic        b_err_o,
  output logic        b_timeout_o,
  input  logic        err_clear_i,
  // Transceiver DRP
  output logic        drp_en_o,
  output logic        drp_we_o,
  output logic [8:0]  drp_addr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_rdy_i
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // Reject an unusable watchdog length at elaboration time.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bert_drp_arbiter: TIMEOUT_CYCLES must be within 2..65535");
  end

  logic [1:0]  state_q, state_d;
  logic        grant_b_q;   // owner of the current transaction (1 = B)
  logic        last_b_q;    // winner of the most recent contested grant
  logic        a_pend_q, a_pend_d, a_we_q;
  logic [8:0]  a_addr_q;
  logic [15:0] a_wdata_q;
  logic        b_pend_q, b_pend_d, b_we_q;
  logic [8:0]  b_addr_q;
  logic [15:0] b_wdata_q;
  logic        drp_en_q, drp_we_q;
  logic [8:0]  drp_addr_q;
  logic [15:0] drp_di_q;
  logic [15:0] a_rdata_q, b_rdata_q;
  logic        a_done_q, b_done_q, a_err_q, b_err_q, a_to_q, b_to_q;

  logic        in_flight, a_busy, b_busy, a_accept, b_accept;
  logic        a_req, b_req, tie, win_b, start;
  logic        rdy_hit, to_hit, txn_end;
  logic        cmd_we;
  logic [8:0]  cmd_addr;
  logic [15:0] cmd_wdata;

  // A port stays busy until its done cycle; in DONE a new command is accepted.
  assign in_flight = (state_q == c_ISSUE) || (state_q == c_WAIT);
  assign a_busy    = a_pend_q | (in_flight & ~grant_b_q);
  assign b_busy    = b_pend_q | (in_flight &  grant_b_q);
  assign a_accept  = a_en_i & ~a_busy;
  assign b_accept  = b_en_i & ~b_busy;

  // A command arriving this cycle competes immediately, so an idle arbiter
  // raises drp_en on the cycle right after the strobe.
  assign a_req = a_pend_q | a_accept;
  assign b_req = b_pend_q | b_accept;
  assign tie   = a_req & b_req;
  assign win_b = tie ? ~last_b_q : b_req;
  assign start = (state_q == c_IDLE) & (a_req | b_req);

  assign rdy_hit = (state_q == c_WAIT) & drp_rdy_i;
  assign txn_end = rdy_hit | to_hit;

  assign a_pend_d = (start & ~win_b) ? 1'b0 : (a_pend_q | a_accept);
  assign b_pend_d = (start &  win_b) ? 1'b0 : (b_pend_q | b_accept);

`ifdef BERT_DRP_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;

  // Watchdog: restart on entering WAIT, count WAIT cycles without drp_rdy.
  always_ff @(posedge drp_clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (state_q == c_ISSUE) begin
      to_cnt_q <= '0;
    end else if ((state_q == c_WAIT) && !drp_rdy_i) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  // drp_rdy in the final wait cycle wins over the abort.
  assign to_hit = (state_q == c_WAIT) & ~drp_rdy_i & (to_cnt_q == c_TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // Select the winner's command, from its buffer or straight from its inputs.
  always_comb begin
    if (win_b) begin
      cmd_we    = b_pend_q ? b_we_q    : b_we_i;
      cmd_addr  = b_pend_q ? b_addr_q  : b_addr_i;
      cmd_wdata = b_pend_q ? b_wdata_q : b_wdata_i;
    end else begin
      cmd_we    = a_pend_q ? a_we_q    : a_we_i;
      cmd_addr  = a_pend_q ? a_addr_q  : a_addr_i;
      cmd_wdata = a_pend_q ? a_wdata_q : a_wdata_i;
    end
  end

  // Transaction sequencing: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (start) state_d = c_ISSUE;
      c_ISSUE: state_d = c_WAIT;
      c_WAIT:  if (txn_end) state_d = c_DONE;
      default: state_d = c_IDLE;
    endcase
  end

  // State, grant bookkeeping and the per-port command buffers.
  always_ff @(posedge drp_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= c_IDLE;
      grant_b_q <= 1'b1;
      last_b_q  <= 1'b1;
      a_pend_q  <= 1'b0;
      a_we_q    <= 1'b0;
      a_addr_q  <= '0;
      a_wdata_q <= '0;
      b_pend_q  <= 1'b0;
      b_we_q    <= 1'b0;
      b_addr_q  <= '0;
      b_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
      if (start) grant_b_q <= win_b;
      // Alternation is tracked between contending ports only, so an
      // uncontested grant does not disturb whose turn the next tie is.
      if (start && tie) last_b_q <= win_b;
      if (a_accept) begin
        a_we_q    <= a_we_i;
        a_addr_q  <= a_addr_i;
        a_wdata_q <= a_wdata_i;
      end
      if (b_accept) begin
        b_we_q    <= b_we_i;
        b_addr_q  <= b_addr_i;
        b_wdata_q <= b_wdata_i;
      end
    end
  end

  // DRP command outputs: strobe for the ISSUE cycle, fields held otherwise.
  always_ff @(posedge drp_clk_i or posedge rst_i) begin
    if (rst_i) begin
      drp_en_q   <= 1'b0;
      drp_we_q   <= 1'b0;
      drp_addr_q <= '0;
      drp_di_q   <= '0;
    end else begin
      drp_en_q <= start;
      if (start) begin
        drp_we_q   <= cmd_we;
        drp_addr_q <= cmd_addr;
        drp_di_q   <= cmd_wdata;
      end
    end
  end

  // Completion, read data, timeout strobes and sticky drop errors per port.
  always_ff @(posedge drp_clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_to_q    <= 1'b0;
      b_to_q    <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      a_done_q <= txn_end & ~grant_b_q;
      b_done_q <= txn_end &  grant_b_q;
      a_to_q   <= to_hit  & ~grant_b_q;
      b_to_q   <= to_hit  &  grant_b_q;
      if (txn_end && !grant_b_q && !drp_we_q) a_rdata_q <= rdy_hit ? drp_do_i : 16'hdead;
      if (txn_end &&  grant_b_q && !drp_we_q) b_rdata_q <= rdy_hit ? drp_do_i : 16'hdead;
      if (err_clear_i)             a_err_q <= 1'b0;
      else if (a_en_i && a_busy)   a_err_q <= 1'b1;
      if (err_clear_i)             b_err_q <= 1'b0;
      else if (b_en_i && b_busy)   b_err_q <= 1'b1;
    end
  end

  assign drp_en_o    = drp_en_q;
  assign drp_we_o    = drp_we_q;
  assign drp_addr_o  = drp_addr_q;
  assign drp_di_o    = drp_di_q;
  assign a_rdata_o   = a_rdata_q;
  assign b_rdata_o   = b_rdata_q;
  assign a_done_o    = a_done_q;
  assign b_done_o    = b_done_q;
  assign a_err_o     = a_err_q;
  assign b_err_o     = b_err_q;
  assign a_timeout_o = a_to_q;
  assign b_timeout_o = b_to_q;

endmodule
`default_nettype wire

// File: tb/tb_bert_drp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bert_drp_arbiter
// Purpose  : Self-checking bench for bert_drp_arbiter: vector table of single
//            transactions plus directed arbitration, error, reset and
//            watchdog sequences (watchdog part under BERT_DRP_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bert_drp_arbiter;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, a_we, b_en, b_we, err_clear, drp_rdy;
  logic [8:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata, drp_do;
  logic [15:0] a_rdata, b_rdata, drp_di;
  logic        a_done, b_done, a_err, b_err, a_timeout, b_timeout;
  logic        drp_en, drp_we;
  logic [8:0]  drp_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  typedef struct {
    bit          port_b;
    bit          we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] dout;
    bit          stray;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  bert_drp_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .drp_clk_i   (clk),
    .rst_i       (rst),
    .a_en_i      (a_en),
    .a_we_i      (a_we),
    .a_addr_i    (a_addr),
    .a_wdata_i   (a_wdata),
    .a_rdata_o   (a_rdata),
    .a_done_o    (a_done),
    .a_err_o     (a_err),
    .a_timeout_o (a_timeout),
    .b_en_i      (b_en),
    .b_we_i      (b_we),
    .b_addr_i    (b_addr),
    .b_wdata_i   (b_wdata),
    .b_rdata_o   (b_rdata),
    .b_done_o    (b_done),
    .b_err_o     (b_err),
    .b_timeout_o (b_timeout),
    .err_clear_i (err_clear),
    .drp_en_o    (drp_en),
    .drp_we_o    (drp_we),
    .drp_addr_o  (drp_addr),
    .drp_di_o    (drp_di),
    .drp_do_i    (drp_do),
    .drp_rdy_i   (drp_rdy)
  );

  always #5 clk = ~clk;

  // Count DRP strobes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (drp_en) en_count <= en_count + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input bit pb, input bit we, input logic [8:0] ad, input logic [15:0] wd);
    if (pb) begin
      b_en = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
    end else begin
      a_en = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
    end
  endtask

  task automatic clear_en;
    a_en = 1'b0;
    b_en = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " drp_en"},   {31'd0, drp_en}, 32'd0);
    check({tag, " drp_we"},   {31'd0, drp_we}, 32'd0);
    check({tag, " drp_addr"}, {23'd0, drp_addr}, 32'd0);
    check({tag, " drp_di"},   {16'd0, drp_di}, 32'd0);
    check({tag, " rdata"},    {a_rdata, b_rdata}, 32'd0);
    check({tag, " done"},     {30'd0, a_done, b_done}, 32'd0);
    check({tag, " err"},      {30'd0, a_err, b_err}, 32'd0);
    check({tag, " timeout"},  {30'd0, a_timeout, b_timeout}, 32'd0);
  endtask

  // Called in the cycle where drp_en must be high.
  task automatic expect_issue(input string tag, input bit we, input logic [8:0] ad, input logic [15:0] wd);
    check({tag, " drp_en"}, {31'd0, drp_en}, 32'd1);
    check({tag, " drp_we/addr/di"}, {6'd0, drp_we, drp_addr, drp_di}, {6'd0, we, ad, wd});
  endtask

  // Called in the ISSUE cycle; returns in the done cycle after checking it.
  task automatic finish_txn(input string tag, input bit pb, input bit stray, input int delay,
                            input logic [15:0] dout, input logic [15:0] exp_rd);
    int bad = 0;
    if (stray) drp_rdy = 1'b1;
    tick;
    clear_en();
    err_clear = 1'b0;
    drp_rdy   = 1'b0;
    for (int i = 1; i < delay; i++) begin
      if (a_done || b_done || drp_en) bad++;
      tick;
    end
    drp_rdy = 1'b1;
    drp_do  = dout;
    tick;
    drp_rdy = 1'b0;
    drp_do  = 16'h0;
    check({tag, " quiet while waiting"}, bad, 0);
    check({tag, " done"}, {30'd0, a_done, b_done}, pb ? 32'd1 : 32'd2);
    check({tag, " rdata"}, {16'd0, (pb ? b_rdata : a_rdata)}, {16'd0, exp_rd});
    check({tag, " timeout"}, {30'd0, a_timeout, b_timeout}, 32'd0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    drive_cmd(v.port_b, v.we, v.addr, v.wdata);
    tick;
    clear_en();
    expect_issue(tag, v.we, v.addr, v.wdata);
    finish_txn(tag, v.port_b, v.stray, v.delay, v.dout, v.exp_rdata);
    tick;
    check({tag, " done one cycle"}, {30'd0, a_done, b_done}, 32'd0);
  endtask

  initial begin
    int base;
    int bad;
    int ticks;

    rst = 1'b1; err_clear = 1'b0; drp_rdy = 1'b0; drp_do = 16'h0;
    a_en = 1'b0; a_we = 1'b0; a_addr = 9'h0; a_wdata = 16'h0;
    b_en = 1'b0; b_we = 1'b0; b_addr = 9'h0; b_wdata = 16'h0;

    //            port_b we    addr    wdata     dly dout      stray exp_rdata
    vecs[0] = '{1'b0, 1'b0, 9'h05F, 16'h0000, 1, 16'h1234, 1'b0, 16'h1234};
    vecs[1] = '{1'b1, 1'b0, 9'h1A3, 16'h0000, 3, 16'hBEEF, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 9'h0FF, 16'hCAFE, 2, 16'h5555, 1'b0, 16'h1234};
    vecs[3] = '{1'b1, 1'b1, 9'h000, 16'h0001, 2, 16'hAAAA, 1'b1, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 9'h1FF, 16'h0000, 5, 16'h0F0F, 1'b1, 16'h0F0F};
    vecs[5] = '{1'b1, 1'b0, 9'h100, 16'h0000, 1, 16'h7E57, 1'b0, 16'h7E57};

    repeat (3) tick;
    check_reset("reset");
    rst = 1'b0;
    tick;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous writes: first tie goes to A, then B.
    base = en_count;
    drive_cmd(1'b0, 1'b1, 9'h011, 16'hA1A1);
    drive_cmd(1'b1, 1'b1, 9'h122, 16'hB2B2);
    tick;
    clear_en();
    expect_issue("pair1 A", 1'b1, 9'h011, 16'hA1A1);
    finish_txn("pair1 A", 1'b0, 1'b0, 1, 16'h1111, 16'h0F0F);
    tick;
    check("pair1 gap", {31'd0, drp_en}, 32'd0);
    tick;
    expect_issue("pair1 B", 1'b1, 9'h122, 16'hB2B2);
    finish_txn("pair1 B", 1'b1, 1'b0, 1, 16'h2222, 16'h7E57);
    tick;
    check("pair1 strobes", en_count - base, 2);

    // Second tie alternates: B first, then A.
    base = en_count;
    drive_cmd(1'b0, 1'b1, 9'h033, 16'hA3A3);
    drive_cmd(1'b1, 1'b1, 9'h144, 16'hB4B4);
    tick;
    clear_en();
    expect_issue("pair2 B", 1'b1, 9'h144, 16'hB4B4);
    finish_txn("pair2 B", 1'b1, 1'b0, 2, 16'h3333, 16'h7E57);
    tick;
    tick;
    expect_issue("pair2 A", 1'b1, 9'h033, 16'hA3A3);
    finish_txn("pair2 A", 1'b0, 1'b0, 1, 16'h4444, 16'h0F0F);
    tick;
    check("pair2 strobes", en_count - base, 2);

    // Re-request while in flight is dropped and flagged.
    base = en_count;
    drive_cmd(1'b0, 1'b0, 9'h0AA, 16'h0000);
    tick;
    clear_en();
    expect_issue("busy", 1'b0, 9'h0AA, 16'h0000);
    drive_cmd(1'b0, 1'b0, 9'h0BB, 16'h0000);
    tick;
    clear_en();
    check("busy a_err set", {30'd0, a_err, b_err}, 32'd2);
    drp_rdy = 1'b1; drp_do = 16'h5A5A;
    tick;
    drp_rdy = 1'b0; drp_do = 16'h0;
    check("busy done", {30'd0, a_done, b_done}, 32'd2);
    check("busy rdata", {16'd0, a_rdata}, 32'h5A5A);
    tick;
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    check("err_clear", {31'd0, a_err}, 32'd0);
    repeat (3) tick;
    check("busy single strobe", en_count - base, 1);

    // err_clear wins over a simultaneous drop; en at done is accepted.
    drive_cmd(1'b0, 1'b0, 9'h0CC, 16'h0000);
    tick;
    clear_en();
    expect_issue("clr prio", 1'b0, 9'h0CC, 16'h0000);
    drive_cmd(1'b0, 1'b0, 9'h0EE, 16'h0000);
    err_clear = 1'b1;
    finish_txn("clr prio", 1'b0, 1'b0, 1, 16'h0C0C, 16'h0C0C);
    check("clr prio a_err", {31'd0, a_err}, 32'd0);
    drive_cmd(1'b0, 1'b0, 9'h0DD, 16'h0000);
    tick;
    clear_en();
    check("en at done no err", {31'd0, a_err}, 32'd0);
    check("en at done idle gap", {31'd0, drp_en}, 32'd0);
    tick;
    expect_issue("en at done", 1'b0, 9'h0DD, 16'h0000);
    finish_txn("en at done", 1'b0, 1'b0, 1, 16'h0D0D, 16'h0D0D);
    tick;

    // Reset while A waits and B is buffered.
    drive_cmd(1'b0, 1'b0, 9'h077, 16'h0000);
    tick;
    clear_en();
    expect_issue("rst", 1'b0, 9'h077, 16'h0000);
    drive_cmd(1'b1, 1'b0, 9'h188, 16'h0000);
    tick;
    clear_en();
    rst = 1'b1;
    #1;
    check_reset("mid rst");
    base = en_count;
    tick;
    rst = 1'b0;
    drp_rdy = 1'b1; drp_do = 16'hFFFF;
    tick;
    drp_rdy = 1'b0; drp_do = 16'h0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_done || b_done || drp_en) bad++;
      tick;
    end
    check("post rst silent", bad, 0);
    check("post rst no strobe", en_count - base, 0);
    check("post rst rdata", {a_rdata, b_rdata}, 32'd0);
    run_vec("post rst", '{1'b1, 1'b0, 9'h123, 16'h0000, 1, 16'h4321, 1'b0, 16'h4321});

`ifdef BERT_DRP_TIMEOUT_EN
    // Watchdog abort on a B read: TO wait cycles, then done + timeout.
    drive_cmd(1'b1, 1'b0, 9'h1EE, 16'h0000);
    tick;
    clear_en();
    expect_issue("timeout", 1'b0, 9'h1EE, 16'h0000);
    ticks = 0;
    do begin
      tick;
      ticks++;
    end while (!b_done && ticks < 200);
    check("timeout latency", ticks, TO + 1);
    check("timeout flags", {28'd0, a_done, b_done, a_timeout, b_timeout}, 32'h5);
    check("timeout rdata", {16'd0, b_rdata}, 32'hDEAD);
    tick;
    check("timeout strobe width", {30'd0, b_done, b_timeout}, 32'd0);
    run_vec("after timeout", '{1'b0, 1'b0, 9'h031, 16'h0000, 1, 16'h1111, 1'b0, 16'h1111});
    run_vec("rdy final cycle", '{1'b1, 1'b0, 9'h1EF, 16'h0000, TO, 16'h2222, 1'b0, 16'h2222});
`else
    // No watchdog: a very late drp_rdy still completes normally.
    run_vec("slow rdy", '{1'b1, 1'b0, 9'h0AB, 16'h0000, 1000, 16'h3333, 1'b0, 16'h3333});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
